// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressable data memory behind a single-request
// load/store front end. A request is accepted in IDLE, optionally waits
// WAIT_CYCLES, then answers with a one-cycle rsp_valid strobe. Storage is
// split into four byte-lane arrays so sub-word stores only touch their lanes.
module data_mem_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);
  localparam logic [32:0] DEPTH_L = 33'(DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [3:0]  cnt_reg;

  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;

  logic        rsp_valid_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  logic        accept;
  logic        resp_entry;

  // Fields of the access being worked on. In IDLE this is the incoming
  // request (needed when WAIT_CYCLES=0 and RESP is entered on the accept
  // edge); otherwise it is the latched copy.
  logic        cur_we;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic        is_byte, is_half, is_word;
  logic        type_ok, misaligned, out_of_range, acc_err;
  logic [3:0]  byte_en;
  logic [31:0] wr_data;
  logic        mem_we;
  logic [AW-1:0] mem_idx;
  logic [31:0] rd_word;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;

  assign req_ready = (state_reg == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  assign cur_we     = (state_reg == IDLE) ? req_we     : we_reg;
  assign cur_funct3 = (state_reg == IDLE) ? req_funct3 : funct3_reg;
  assign cur_addr   = (state_reg == IDLE) ? req_addr   : addr_reg;
  assign cur_wdata  = (state_reg == IDLE) ? req_wdata  : wdata_reg;

  // Next-state logic for the IDLE -> (WAIT) -> RESP -> IDLE sequence
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (WAIT_L != 4'd0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_reg <= 4'd1) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory is written and read on the edge that moves the FSM into RESP
  assign resp_entry = (state_next == RESP) && (state_reg != RESP) && !rst;

  // State register and wait counter; counter reloads on every accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cnt_reg <= WAIT_L;
      end else if ((state_reg == WAIT) && (cnt_reg != 4'd0)) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  // Capture the request fields on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg     <= req_we;
      funct3_reg <= req_funct3;
      addr_reg   <= req_addr;
      wdata_reg  <= req_wdata;
    end
  end

  // Access decode: size, legality and byte-lane selection
  always_comb begin
    is_byte = (cur_funct3[1:0] == 2'b00);
    is_half = (cur_funct3[1:0] == 2'b01);
    is_word = (cur_funct3 == 3'b010);

    if (cur_we) begin
      type_ok = !cur_funct3[2] && (cur_funct3[1:0] != 2'b11);
    end else begin
      type_ok = cur_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end

    misaligned   = (is_half && cur_addr[0]) ||
                   (is_word && (cur_addr[1:0] != 2'b00));
    out_of_range = ({3'b000, cur_addr[31:2]} >= DEPTH_L);
    acc_err      = !type_ok || misaligned || out_of_range;

    byte_en = 4'b0000;
    wr_data = cur_wdata;
    if (is_byte) begin
      byte_en = 4'b0001 << cur_addr[1:0];
      wr_data = {4{cur_wdata[7:0]}};
    end else if (is_half) begin
      byte_en = cur_addr[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{cur_wdata[15:0]}};
    end else if (is_word) begin
      byte_en = 4'b1111;
    end
  end

  assign mem_we  = resp_entry && cur_we && !acc_err;
  assign mem_idx = cur_addr[AW+1:2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH_WORDS];
      logic [7:0] rd_byte_reg;

      // One byte lane of storage: lane-enabled write, registered read
      always_ff @(posedge clk) begin
        if (mem_we && byte_en[gi]) begin
          mem_lane[mem_idx] <= wr_data[gi*8 +: 8];
        end
        if (resp_entry) begin
          rd_byte_reg <= mem_lane[mem_idx];
        end
      end

      assign rd_word[gi*8 +: 8] = rd_byte_reg;
    end
  endgenerate

  // Lane extraction and sign/zero extension of the word read for a load
  always_comb begin
    lane_byte = rd_word[{cur_addr[1:0], 3'b000} +: 8];
    lane_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (cur_funct3)
      3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_val = {24'h000000, lane_byte};
      3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_val = {16'h0000, lane_half};
      3'b010:  load_val = rd_word;
      default: load_val = 32'h0000_0000;
    endcase
  end

  // Response registers: strobe for one cycle as RESP exits, hold data after
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'h0000_0000;
      rsp_err_reg   <= 1'b0;
    end else if (state_reg == RESP) begin
      rsp_valid_reg <= 1'b1;
      rsp_err_reg   <= acc_err;
      rsp_rdata_reg <= (acc_err || cur_we) ? 32'h0000_0000 : load_val;
    end else begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Testbench for data_mem_lsu: directed scenarios plus randomized accesses
// checked against a byte-array reference model of the memory.
module tb_data_mem_lsu;

  localparam int DEPTH = 1024;
  localparam int WAIT  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] model_mem [DEPTH*4];

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  data_mem_lsu #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Reference model: memory as a flat little-endian byte array
  function automatic void model_access(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rd, output logic er);
    int size;
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    rd = 32'h0;
    er = (size == 0) || (we && f3[2]);
    if (!er && ((addr % size) != 0)) er = 1'b1;
    if ((addr >> 2) >= DEPTH) er = 1'b1;
    if (er) return;
    if (we) begin
      for (int b = 0; b < size; b++) model_mem[addr + b] = wdata[8*b +: 8];
    end else begin
      v = 32'h0;
      for (int b = 0; b < size; b++) v = v + (32'(model_mem[addr + b]) << (8*b));
      if (f3 == 3'b000 && v >= 32'h80)   v = v - 32'h100;
      if (f3 == 3'b001 && v >= 32'h8000) v = v - 32'h10000;
      rd = v;
    end
  endfunction

  // Drive one request and wait for its response; latency counted in cycles
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rd,
                            output logic er, output int lat);
    int guard;
    rd = 32'h0; er = 1'b0; lat = -1;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 64) begin @(negedge clk); guard++; end
    if (guard >= 64) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: req_ready=%b, required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
    if (lat >= 64) begin
      n_vec++; n_err++;
      $display("FAIL rsp_timeout: rsp_valid=%b, required 1", rsp_valid);
      return;
    end
    rd = rsp_rdata; er = rsp_err;
    $display("txn we=%0d f3=%03b addr=%08h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
             we, f3, addr, wdata, rd, er, lat);
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b, required 0", req_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h, required 0", rsp_rdata); end
    n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b, required 0", rsp_err); end
    rst = 1'b0; req_valid = 1'b0;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b, required 1", req_ready); end
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid !== 1'b0) seen++; end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL reset_no_rsp: strobes=%0d, required 0", seen); end
  endtask

  task automatic test_init();
    logic [31:0] rd, exp_rd; logic er, exp_er; int lat; logic [31:0] d;
    for (int w = 0; w < 64; w++) begin
      d = $urandom;
      model_access(1'b1, 3'b010, 32'(w*4), d, exp_rd, exp_er);
      run_access(1'b1, 3'b010, 32'(w*4), d, rd, er, lat);
      n_vec++;
      if (rd !== exp_rd || er !== exp_er || lat != 1 + WAIT) begin
        n_err++;
        $display("FAIL init[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                 w, rd, er, lat, exp_rd, exp_er, 1 + WAIT);
      end
    end
  endtask

  task automatic test_directed();
    vec_t tbl[24];
    logic [31:0] rd, m_rd; logic er, m_er; int lat;
    tbl[0]  = '{1'b1, 3'b010, 32'h10,   32'h8000_00FF, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 3'b010, 32'h10,   32'h0,         32'h8000_00FF, 1'b0};
    tbl[2]  = '{1'b1, 3'b000, 32'h13,   32'h1234_56A5, 32'h0,         1'b0};
    tbl[3]  = '{1'b0, 3'b000, 32'h13,   32'h0,         32'hFFFF_FFA5, 1'b0};
    tbl[4]  = '{1'b0, 3'b100, 32'h13,   32'h0,         32'h0000_00A5, 1'b0};
    tbl[5]  = '{1'b0, 3'b010, 32'h10,   32'h0,         32'hA500_00FF, 1'b0};
    tbl[6]  = '{1'b0, 3'b001, 32'h11,   32'h0,         32'h0,         1'b1};
    tbl[7]  = '{1'b1, 3'b010, 32'h12,   32'hDEAD_BEEF, 32'h0,         1'b1};
    tbl[8]  = '{1'b0, 3'b010, 32'h10,   32'h0,         32'hA500_00FF, 1'b0};
    tbl[9]  = '{1'b0, 3'b010, 32'h1000, 32'h0,         32'h0,         1'b1};
    tbl[10] = '{1'b0, 3'b011, 32'h10,   32'h0,         32'h0,         1'b1};
    tbl[11] = '{1'b1, 3'b100, 32'h10,   32'hFFFF_FFFF, 32'h0,         1'b1};
    tbl[12] = '{1'b1, 3'b011, 32'h10,   32'hFFFF_FFFF, 32'h0,         1'b1};
    tbl[13] = '{1'b0, 3'b110, 32'h10,   32'h0,         32'h0,         1'b1};
    tbl[14] = '{1'b0, 3'b010, 32'h10,   32'h0,         32'hA500_00FF, 1'b0};
    tbl[15] = '{1'b1, 3'b001, 32'h12,   32'h1234_BEEF, 32'h0,         1'b0};
    tbl[16] = '{1'b0, 3'b001, 32'h12,   32'h0,         32'hFFFF_BEEF, 1'b0};
    tbl[17] = '{1'b0, 3'b101, 32'h12,   32'h0,         32'h0000_BEEF, 1'b0};
    tbl[18] = '{1'b0, 3'b010, 32'h10,   32'h0,         32'hBEEF_00FF, 1'b0};
    tbl[19] = '{1'b1, 3'b010, 32'hFFC,  32'h0BAD_F00D, 32'h0,         1'b0};
    tbl[20] = '{1'b0, 3'b010, 32'hFFC,  32'h0,         32'h0BAD_F00D, 1'b0};
    tbl[21] = '{1'b0, 3'b000, 32'hFFF,  32'h0,         32'h0000_000B, 1'b0};
    tbl[22] = '{1'b0, 3'b001, 32'hFFE,  32'h0,         32'h0000_0BAD, 1'b0};
    tbl[23] = '{1'b0, 3'b000, 32'h1000, 32'h0,         32'h0,         1'b1};
    for (int i = 0; i < 24; i++) begin
      model_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_rd, m_er);
      run_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er, lat);
      n_vec++;
      if (rd !== tbl[i].rd || er !== tbl[i].er || lat != 1 + WAIT) begin
        n_err++;
        $display("FAIL directed[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                 i, rd, er, lat, tbl[i].rd, tbl[i].er, 1 + WAIT);
      end
    end
  endtask

  task automatic test_wait_timing();
    logic [31:0] exp_rd; logic exp_er; int period;
    period = 2 + WAIT;
    model_access(1'b0, 3'b010, 32'h10, 32'h0, exp_rd, exp_er);
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
    for (int i = 0; i < 4 * period; i++) begin
      if (i > 0) @(negedge clk);
      n_vec++;
      if (req_ready !== 1'((i % period) == 0)) begin
        n_err++; $display("FAIL timing_ready[%0d]: got %b, required %b", i, req_ready, (i % period) == 0);
      end
      n_vec++;
      if (rsp_valid !== 1'((i > 0) && ((i % period) == 0))) begin
        n_err++; $display("FAIL timing_valid[%0d]: got %b, required %b", i, rsp_valid, (i > 0) && ((i % period) == 0));
      end
      if (rsp_valid === 1'b1) begin
        $display("txn held-valid LW addr=00000010 -> rdata=%08h err=%0d cycle=%0d", rsp_rdata, rsp_err, i);
        n_vec++;
        if (rsp_rdata !== exp_rd || rsp_err !== exp_er) begin
          n_err++; $display("FAIL timing_data[%0d]: got %h/%b, required %h/%b", i, rsp_rdata, rsp_err, exp_rd, exp_er);
        end
      end
    end
    req_valid = 1'b0;
    repeat (period + 1) @(negedge clk);
  endtask

  task automatic test_hold();
    logic [31:0] rd, exp_rd; logic er, exp_er; int lat;
    for (int t = 0; t < 2; t++) begin
      model_access(1'b0, 3'b010, (t == 0) ? 32'h10 : 32'h1000, 32'h0, exp_rd, exp_er);
      run_access(1'b0, 3'b010, (t == 0) ? 32'h10 : 32'h1000, 32'h0, rd, er, lat);
      n_vec++;
      if (rd !== exp_rd || er !== exp_er) begin
        n_err++; $display("FAIL hold_rsp[%0d]: got %h/%b, required %h/%b", t, rd, er, exp_rd, exp_er);
      end
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== exp_rd || rsp_err !== exp_er) begin
          n_err++;
          $display("FAIL hold[%0d.%0d]: valid=%b rdata=%h err=%b, required valid=0 rdata=%h err=%b",
                   t, i, rsp_valid, rsp_rdata, rsp_err, exp_rd, exp_er);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, exp_rd; logic er, exp_er; int lat, guard, seen;
    model_access(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, exp_rd, exp_er);
    run_access(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, rd, er, lat);
    n_vec++;
    if (er !== 1'b0) begin n_err++; $display("FAIL abort_setup: err=%b, required 0", er); end
    for (int k = 1; k <= WAIT; k++) begin
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20;
      req_wdata = (k == 1) ? 32'h1234_5678 : ($urandom ^ 32'hCAFE_F00D) | 32'h1;
      req_valid = 1'b1;
      guard = 0;
      while (req_ready !== 1'b1 && guard < 64) begin @(negedge clk); guard++; end
      if (guard >= 64) begin
        n_err++; $display("FAIL abort_accept[%0d]: req_ready=%b, required 1", k, req_ready);
      end
      @(posedge clk);
      for (int j = 0; j < k; j++) begin @(negedge clk); req_valid = 1'b0; end
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL abort_in_reset[%0d]: ready=%b valid=%b, required 0/0", k, req_ready, rsp_valid);
      end
      rst = 1'b0;
      seen = 0;
      repeat (8) begin @(negedge clk); if (rsp_valid !== 1'b0) seen++; end
      n_vec++;
      if (seen != 0) begin n_err++; $display("FAIL abort_no_rsp[%0d]: strobes=%0d, required 0", k, seen); end
      n_vec++;
      if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
        n_err++; $display("FAIL abort_cleared[%0d]: rdata=%h err=%b, required 0/0", k, rsp_rdata, rsp_err);
      end
      model_access(1'b0, 3'b010, 32'h20, 32'h0, exp_rd, exp_er);
      run_access(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
      n_vec++;
      if (rd !== exp_rd || er !== exp_er) begin
        n_err++; $display("FAIL abort_contents[%0d]: got %h/%b, required %h/%b", k, rd, er, exp_rd, exp_er);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, addr, wdata; logic er, exp_er, we; logic [2:0] f3; int lat;
    logic [2:0] legal_f3 [5];
    legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
    legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;
    for (int i = 0; i < 250; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
      if ($urandom_range(0, 9) < 9) addr = 32'($urandom_range(0, 255));
      else begin addr = $urandom; if (addr < 32'h1000) addr = addr | 32'h1000; end
      wdata = $urandom;
      model_access(we, f3, addr, wdata, exp_rd, exp_er);
      run_access(we, f3, addr, wdata, rd, er, lat);
      n_vec++;
      if (rd !== exp_rd || er !== exp_er || lat != 1 + WAIT) begin
        n_err++;
        $display("FAIL random[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                 i, rd, er, lat, exp_rd, exp_er, 1 + WAIT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_wait_timing();
    test_hold();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
